// File: rtl/timebase_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timebase_pkg
// Description : Shared constants, timer state type and width helper for the
//               timebase generator.
// Revision    : 1.0 - initial release
// ============================================================================
package timebase_pkg;

    // Common configuration points: 50 MHz clock to 1 us, decimal decades.
    localparam int PRE_DIV_50MHZ_1US = 50;
    localparam int DIV_DECIMAL_1000  = 1000;

    // Countdown timer states.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tmr_state_t;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int tb_clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tb_div_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_stage
// Description : Modulo-DIV counter. Advances on in_tick and emits out_tick on
//               the input tick that wraps it back to zero. clr zeroes the
//               count and suppresses the output tick in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_stage
    import timebase_pkg::*;
#(
    parameter int DIV = DIV_DECIMAL_1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_tick,
    output logic out_tick
);

    localparam int             c_W    = tb_clog2(DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);
    localparam logic [c_W-1:0] c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;
    logic           w_wrap;

    assign w_wrap   = in_tick & ~clr & (r_cnt == c_LAST);
    assign out_tick = w_wrap;

    // Count input ticks modulo DIV; clear wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else if (in_tick) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/timebase_gen.sv
`default_nettype none
// ============================================================================
// Module      : timebase_gen
// Description : Prescaler plus cascaded divider stages producing single-cycle
//               ticks, and one programmable one-shot/periodic countdown timer
//               decremented by a selectable tick level.
//               Build option: TIMEBASE_TICK_REG_EN registers the tick outputs
//               (one extra cycle of latency on every level and on the timer).
// Revision    : 1.0 - initial release
// ============================================================================
module timebase_gen
    import timebase_pkg::*;
#(
    parameter int PRE_DIV    = PRE_DIV_50MHZ_1US,
    parameter int NUM_STAGES = 2,
    parameter int STAGE_DIV  = DIV_DECIMAL_1000,
    parameter int TMR_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clr,
    output logic [NUM_STAGES:0]             tick,
    input  logic [$clog2(NUM_STAGES+1)-1:0] tmr_sel,
    input  logic [TMR_W-1:0]                tmr_load,
    input  logic                            tmr_periodic,
    input  logic                            tmr_start,
    input  logic                            tmr_stop,
    output logic                            tmr_busy,
    output logic                            tmr_done,
    output logic [TMR_W-1:0]                tmr_cnt
);

    localparam int               c_SEL_W   = $clog2(NUM_STAGES + 1);
    localparam int               c_PAD_N   = 1 << c_SEL_W;
    localparam logic [TMR_W-1:0] c_CNT_ONE = TMR_W'(1);

    logic [NUM_STAGES:0] w_tick_raw;

    // Level 0 is the prescaler fed by en; level k is fed by level k-1.
    for (genvar k = 0; k <= NUM_STAGES; k++) begin : g_stage
        logic w_in;
        logic w_out;
        if (k == 0) begin : g_first
            assign w_in = en;
        end else begin : g_next
            assign w_in = g_stage[k-1].w_out;
        end
        tb_div_stage #(
            .DIV (k == 0 ? PRE_DIV : STAGE_DIV)
        ) u_div (
            .clk      (clk),
            .rst      (rst),
            .clr      (clr),
            .in_tick  (w_in),
            .out_tick (w_out)
        );
        assign w_tick_raw[k] = w_out;
    end

`ifdef TIMEBASE_TICK_REG_EN
    logic [NUM_STAGES:0] r_tick;

    // Retime all tick levels together so coincident ticks stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick <= '0;
        end else begin
            r_tick <= w_tick_raw;
        end
    end

    assign tick = r_tick;
`else
    assign tick = w_tick_raw;
`endif

    // ------------------------------------------------------------------------
    // Countdown timer
    // ------------------------------------------------------------------------
    logic [c_PAD_N-1:0] w_tick_pad;
    logic               w_tt;
    tmr_state_t         r_state, w_state_nxt;
    logic [TMR_W-1:0]   r_cnt, w_cnt_nxt;
    logic [TMR_W-1:0]   r_reload, w_reload_nxt;
    logic               r_periodic, w_periodic_nxt;
    logic               r_done, w_done_nxt;

    // Zero-pad the tick vector so selector values above NUM_STAGES read 0.
    always_comb begin
        w_tick_pad               = '0;
        w_tick_pad[NUM_STAGES:0] = tick;
    end

    assign w_tt = w_tick_pad[tmr_sel];

    // Timer registers: state, remaining count, reload value, mode, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_reload   <= w_reload_nxt;
            r_periodic <= w_periodic_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // Next-state: stop beats start, start beats expiry/decrement.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_done_nxt     = 1'b0;
        if (tmr_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (tmr_start) begin
            w_reload_nxt   = tmr_load;
            w_periodic_nxt = tmr_periodic;
            if (tmr_load == '0) begin
                // A zero load expires immediately without entering RUN.
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = RUN;
                w_cnt_nxt   = tmr_load;
            end
        end else if (r_state == RUN && w_tt) begin
            if (r_cnt == c_CNT_ONE) begin
                w_done_nxt = 1'b1;
                if (r_periodic) begin
                    w_cnt_nxt = r_reload;
                end else begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end else begin
                w_cnt_nxt = r_cnt - c_CNT_ONE;
            end
        end
    end

    assign tmr_busy = (r_state == RUN);
    assign tmr_done = r_done;
    assign tmr_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_timebase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_timebase_gen
// Description : Self-checking bench for timebase_gen with a cycle-level
//               reference model built from tick periods and timer rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timebase_gen;

    localparam int PRE_DIV    = 5;
    localparam int STAGE_DIV  = 4;
    localparam int NUM_STAGES = 2;
    localparam int TMR_W      = 8;
`ifdef TIMEBASE_TICK_REG_EN
    localparam bit TICK_REG = 1'b1;
`else
    localparam bit TICK_REG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic [2:0] tick;
    logic [1:0] tmr_sel;
    logic [7:0] tmr_load;
    logic       tmr_periodic, tmr_start, tmr_stop;
    logic       tmr_busy, tmr_done;
    logic [7:0] tmr_cnt;

    timebase_gen #(
        .PRE_DIV    (PRE_DIV),
        .NUM_STAGES (NUM_STAGES),
        .STAGE_DIV  (STAGE_DIV),
        .TMR_W      (TMR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clr          (clr),
        .tick         (tick),
        .tmr_sel      (tmr_sel),
        .tmr_load     (tmr_load),
        .tmr_periodic (tmr_periodic),
        .tmr_start    (tmr_start),
        .tmr_stop     (tmr_stop),
        .tmr_busy     (tmr_busy),
        .tmr_done     (tmr_done),
        .tmr_cnt      (tmr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: m_e = enabled edges since the last clear/reset.
    int         m_e;
    logic [2:0] m_tick_q;
    logic       m_busy, m_done, m_per;
    logic [7:0] m_cnt, m_reload;
    int         n_assert = 0;
    int         n_fail   = 0;

    function automatic int period(input int k);
        int p;
        p = PRE_DIV;
        for (int i = 0; i < k; i++) p = p * STAGE_DIV;
        return p;
    endfunction

    function automatic logic [2:0] m_raw();
        logic [2:0] r;
        for (int k = 0; k <= NUM_STAGES; k++)
            r[k] = en && !clr && (((m_e + 1) % period(k)) == 0);
        return r;
    endfunction

    function automatic logic [2:0] m_tick_exp();
        return TICK_REG ? m_tick_q : m_raw();
    endfunction

    function automatic logic m_tt();
        logic [2:0] t;
        t = m_tick_exp();
        return (tmr_sel <= 2'd2) ? t[tmr_sel] : 1'b0;
    endfunction

    task automatic m_reset();
        m_e = 0; m_tick_q = '0; m_busy = 0; m_done = 0; m_per = 0;
        m_cnt = '0; m_reload = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model update at a clock edge, using the inputs present before the edge.
    task automatic m_edge();
        logic [2:0] raw;
        logic       tt, nd;
        if (rst) begin
            m_reset();
            return;
        end
        raw = m_raw();
        tt  = m_tt();
        nd  = 1'b0;
        if (tmr_stop) begin
            m_busy = 0; m_cnt = '0;
        end else if (tmr_start) begin
            m_reload = tmr_load; m_per = tmr_periodic;
            if (tmr_load == 0) begin
                m_busy = 0; m_cnt = '0; nd = 1'b1;
            end else begin
                m_busy = 1; m_cnt = tmr_load;
            end
        end else if (m_busy && tt) begin
            if (m_cnt == 8'd1) begin
                nd = 1'b1;
                if (m_per) m_cnt = m_reload;
                else begin m_cnt = '0; m_busy = 0; end
            end else begin
                m_cnt = m_cnt - 8'd1;
            end
        end
        m_done   = nd;
        m_tick_q = raw;
        if (clr) m_e = 0;
        else if (en) m_e = m_e + 1;
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model.
    task automatic step();
        @(negedge clk);
        check("tick", {29'd0, tick}, {29'd0, m_tick_exp()});
        check("busy", {31'd0, tmr_busy}, {31'd0, m_busy});
        check("done", {31'd0, tmr_done}, {31'd0, m_done});
        check("cnt", {24'd0, tmr_cnt}, {24'd0, m_cnt});
        @(posedge clk);
        m_edge();
        #1;
    endtask

    int n_done;
    int hit;

    initial begin
        rst = 1; en = 0; clr = 0; tmr_sel = 0; tmr_load = 0;
        tmr_periodic = 0; tmr_start = 0; tmr_stop = 0;
        m_reset();
        repeat (3) step();
        rst = 0;

        // Free-running ticks across all three levels.
        en = 1;
        repeat (170) step();

        // Freeze with pre_cnt at 3, then resume.
        for (int i = 0; i < 10 && (m_e % PRE_DIV) != 3; i++) step();
        en = 0;
        repeat (7) step();
        en = 1;
        repeat (12) step();

        // Clear mid-count.
        repeat (3) step();
        clr = 1; step(); clr = 0;
        repeat (12) step();

        // One-shot on tick[0].
        tmr_sel = 0; tmr_load = 3; tmr_periodic = 0; tmr_start = 1;
        step(); tmr_start = 0;
        n_done = 0;
        repeat (20) begin step(); if (tmr_done) n_done++; end
        check("oneshot_dones", n_done, 1);
        check("oneshot_busy", {31'd0, tmr_busy}, 0);

        // Periodic on tick[1], aligned by a clear: four periods of 40.
        tmr_sel = 1; tmr_load = 2; tmr_periodic = 1; tmr_start = 1; clr = 1;
        step(); tmr_start = 0; clr = 0;
        n_done = 0;
        repeat (165) begin step(); if (tmr_done) n_done++; end
        check("periodic_dones", n_done, 4);
        tmr_stop = 1; step(); tmr_stop = 0;
        n_done = 0;
        repeat (60) begin step(); if (tmr_done) n_done++; end
        check("stopped_dones", n_done, 0);
        check("stopped_busy", {31'd0, tmr_busy}, 0);

        // Zero load: immediate done, never busy.
        tmr_sel = 0; tmr_load = 0; tmr_periodic = 0; tmr_start = 1;
        step(); tmr_start = 0;
        check("zero_done", {31'd0, tmr_done}, 1);
        check("zero_busy", {31'd0, tmr_busy}, 0);
        step();

        // Start and stop together.
        tmr_load = 5; tmr_start = 1; tmr_stop = 1;
        step(); tmr_start = 0; tmr_stop = 0;
        check("startstop_busy", {31'd0, tmr_busy}, 0);
        check("startstop_cnt", {24'd0, tmr_cnt}, 0);

        // Restart exactly when count==1 coincides with the selected tick.
        tmr_load = 2; tmr_start = 1;
        step(); tmr_start = 0;
        hit = 0;
        for (int i = 0; i < 30 && hit == 0; i++) begin
            if (m_busy && m_cnt == 8'd1 && m_tt()) begin
                tmr_load = 6; tmr_start = 1;
                step(); tmr_start = 0;
                hit = 1;
            end else begin
                step();
            end
        end
        check("restart_hit", hit, 1);
        check("restart_done", {31'd0, tmr_done}, 0);
        check("restart_cnt", {24'd0, tmr_cnt}, 6);
        tmr_stop = 1; step(); tmr_stop = 0;

        // Selector beyond the last level never decrements.
        tmr_sel = 3; tmr_load = 2; tmr_start = 1;
        step(); tmr_start = 0;
        repeat (100) step();
        check("sel3_cnt", {24'd0, tmr_cnt}, 2);
        check("sel3_busy", {31'd0, tmr_busy}, 1);
        tmr_stop = 1; step(); tmr_stop = 0;

        // Asynchronous reset while running.
        tmr_sel = 0; tmr_load = 5; tmr_start = 1;
        step(); tmr_start = 0;
        repeat (3) step();
        #2; rst = 1; m_reset();
        #1;
        check("arst_busy", {31'd0, tmr_busy}, 0);
        check("arst_cnt", {24'd0, tmr_cnt}, 0);
        check("arst_done", {31'd0, tmr_done}, 0);
        check("arst_tick", {29'd0, tick}, 0);
        step();
        rst = 0;

        // Randomized traffic against the model.
        repeat (400) begin
            en           = ($urandom % 8) != 0;
            clr          = ($urandom % 40) == 0;
            tmr_start    = ($urandom % 25) == 0;
            tmr_stop     = ($urandom % 60) == 0;
            tmr_load     = 8'($urandom % 8);
            tmr_sel      = 2'($urandom % 4);
            tmr_periodic = 1'($urandom % 2);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/timebase_gen.md
Name: timebase_gen

Overview:
- Parametrised timebase generator: prescaler plus cascaded divider stages produce single-cycle ticks at 1 us, 1 ms, 1 s, and so on.
- Adds global enable/clear and one programmable countdown timer (one-shot or periodic) clocked from a selectable tick level.
- Sits beside every block needing time references; replaces per-block hand-rolled us/10us counters.

Parameters:
- PRE_DIV, 50, clk cycles per tick[0] (50 MHz -> 1 us); must be >= 2.
- NUM_STAGES, 2, divider stages after the prescaler; >= 1.
- STAGE_DIV, 1000, division ratio of each stage; >= 2.
- TMR_W, 16, timer load/count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  prescaler/stage count enable.
- clr  in  1  synchronous clear of prescaler and stage counters.
- tick  out  NUM_STAGES+1  tick[0] = prescaler tick; tick[k] = stage k tick; each 1-cycle pulse.
- tmr_sel  in  $clog2(NUM_STAGES+1)  tick index that decrements the timer.
- tmr_load  in  TMR_W  timer start value.
- tmr_periodic  in  1  1 = auto-reload, 0 = one-shot; sampled at start.
- tmr_start  in  1  start/restart pulse.
- tmr_stop  in  1  abort pulse.
- tmr_busy  out  1  timer in RUN.
- tmr_done  out  1  1-cycle expiry pulse.
- tmr_cnt  out  TMR_W  current remaining count.

Interface: one clock (clk); reset is asynchronous and active-high (rst). All outputs are 0 in reset.

Behaviour:
- Prescaler pre_cnt runs 0..PRE_DIV-1 and advances only when en=1.
- tick_raw[0] = en & (pre_cnt==PRE_DIV-1); pre_cnt wraps to 0 on that cycle.
- Stage k counter runs 0..STAGE_DIV-1 and advances on tick_raw[k-1].
- tick_raw[k] = tick_raw[k-1] & (stg_cnt[k]==STAGE_DIV-1); the stage wraps to 0 on that cycle.
- tick = tick_raw, combinational from registers: 0 added latency. All coincident ticks assert in the same cycle.
- en=0: all counters hold and no ticks are produced. Resuming continues from the held values.
- clr=1: pre_cnt and all stage counters become 0 next edge; tick forced 0 that cycle. clr has priority over en.
- Counter widths: $clog2(PRE_DIV) and $clog2(STAGE_DIV); constants sized to the counter width, no truncation.
- Timer FSM states are IDLE and RUN. Timer tick tt = tick[tmr_sel]; if tmr_sel > NUM_STAGES, tt = 0.
- IDLE + tmr_start:
  - Latch tmr_load into the reload register and tmr_periodic into the mode register.
  - If tmr_load==0: tmr_done pulses next cycle and the FSM stays IDLE.
  - Otherwise: tmr_cnt = tmr_load, go to RUN.
- RUN + tt with tmr_cnt>1: decrement tmr_cnt.
- RUN + tt with tmr_cnt==1: tmr_done=1 next cycle.
  - Periodic: tmr_cnt = reload, stay RUN.
  - One-shot: tmr_cnt = 0, go to IDLE.
- RUN + tmr_start: restart with new tmr_load/tmr_periodic. No done, even if tt coincides.
- tmr_stop (any state): go to IDLE, tmr_cnt = 0, no done. tmr_stop beats tmr_start and expiry in the same cycle.
- tmr_busy = (state==RUN), registered. tmr_done is registered: 1 cycle after the expiring tt.
- clr and en do not touch timer state; they only gate ticks.
- rst mid-operation: everything returns to 0/IDLE immediately; no done pulse.

Optional Feature:
- TIMEBASE_TICK_REG_EN defined: tick outputs come from flops, one cycle after tick_raw; all levels are delayed equally. The timer still uses the registered tick, so tmr_done lands 2 cycles after the raw expiry tick.
- Undefined: combinational ticks as above.

Decomposition:
- Package timebase_pkg holds:
  - default constants (PRE_DIV_50MHZ_1US=50, DIV_DECIMAL_1000=1000);
  - typedef tmr_state_t {IDLE, RUN};
  - a function tb_clog2 for width derivation.
- Sub-module tb_div_stage: one modulo-N counter with in-tick and out-tick, instantiated once per stage by a generate loop. The prescaler is an instance with in-tick = en.

Test Plan (PRE_DIV=5, STAGE_DIV=4, NUM_STAGES=2, TMR_W=8 unless noted):
- Ticks: en=1 after reset -> tick[0] first high at the 5th enabled edge, then every 5 cycles. tick[1] every 20 cycles, tick[2] every 80, coincident with tick[1]/tick[0].
- Freeze/clear: drop en at pre_cnt=3 for 7 cycles -> no ticks, resume with tick[0] 2 cycles later. clr mid-count -> next tick[0] exactly 5 enabled cycles after clr.
- One-shot: tmr_sel=0, tmr_load=3, start -> busy 1; tmr_done one cycle after the 3rd tick[0] (~15 cycles); busy 0, tmr_cnt 0.
- Periodic: tmr_sel=1, tmr_load=2, periodic=1 -> tmr_done every 40 cycles for 4 periods. tmr_stop then -> busy 0, no further done.
- Corners:
  - load=0 start -> done next cycle, busy stays 0.
  - start+stop same cycle -> IDLE.
  - restart at tmr_cnt==1 coincident with tt -> no done, tmr_cnt = new load.
  - tmr_sel=3 -> never decrements.
  - rst asserted mid-RUN -> all outputs 0 asynchronously.
- Macro: with TIMEBASE_TICK_REG_EN, repeat scenarios 1 and 3 -> every tick and tmr_done shifted exactly +1 cycle.
